// File: rtl/imm_pkg.sv
// Shared types and field positions for the RV32 immediate-generation stage.
//   imm_fmt_t : immediate format select carried alongside each instruction
//   *_LSB     : opcode-free bit positions of the immediate fields in instr
package imm_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned FMT_W    = 3;
  localparam int unsigned FIELD5_W = 5;

  typedef enum logic [FMT_W-1:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_CSR   = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_fmt_t;

  // Field positions inside the instruction word
  localparam int unsigned SIGN_BIT  = 31;
  localparam int unsigned I_IMM_LSB = 20;  // I-type imm[11:0]
  localparam int unsigned S_HI_LSB  = 25;  // S/B-type upper field
  localparam int unsigned S_LO_LSB  = 7;   // S-type imm[4:0]
  localparam int unsigned U_IMM_LSB = 12;  // U-type imm[31:12]
  localparam int unsigned RS1_LSB   = 15;  // CSR uimm lives in rs1
  localparam int unsigned RS2_LSB   = 20;  // shamt lives in rs2

endpackage : imm_pkg

// File: rtl/imm_decode.sv
// Combinational immediate extractor for all RV32I/Zicsr formats.
//   instr   in  32          instruction word (opcode bits ignored)
//   imm_fmt in  3           format select (imm_fmt_t encoding)
//   imm_ext out DATA_WIDTH  sign/zero-extended immediate
//   fmt_err out 1           imm_fmt was the reserved code
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [INSTR_W-1:0]    instr,
  input  logic [FMT_W-1:0]      imm_fmt,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic                  fmt_err
);

  logic                 w_sign;
  logic [INSTR_W-1:0]   w_base;
  logic                 w_unused_opcode;

  assign w_sign          = instr[SIGN_BIT];
  assign w_unused_opcode = ^instr[6:0];

  // Build a 32-bit immediate; zero-extended formats keep bit 31 clear so the
  // single sign-extension to DATA_WIDTH below is correct for every format.
  always_comb begin
    w_base  = '0;
    fmt_err = 1'b0;
    case (imm_fmt_t'(imm_fmt))
      IMM_I:     w_base = {{20{w_sign}}, instr[I_IMM_LSB +: 12]};
      IMM_S:     w_base = {{20{w_sign}}, instr[S_HI_LSB +: 7], instr[S_LO_LSB +: 5]};
      IMM_B:     w_base = {{19{w_sign}}, w_sign, instr[7], instr[30:25],
                           instr[11:8], 1'b0};
      IMM_U:     w_base = {instr[U_IMM_LSB +: 20], 12'b0};
      IMM_J:     w_base = {{11{w_sign}}, w_sign, instr[19:12], instr[20],
                           instr[30:21], 1'b0};
      IMM_SHAMT: w_base = {27'b0, instr[RS2_LSB +: FIELD5_W]};
      IMM_CSR:   w_base = {27'b0, instr[RS1_LSB +: FIELD5_W]};
      default: begin
        w_base  = '0;
        fmt_err = 1'b1;
      end
    endcase
  end

  assign imm_ext = DATA_WIDTH'($signed(w_base));

endmodule : imm_decode

// File: rtl/imm_gen_stage.sv
// Pipelined immediate-generation stage with a 2-entry skid buffer.
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   instr, imm_fmt      instruction word and format select
//   in_tag              sideband passed through unmodified
//   flush               drop every held entry and the current input
//   out_valid/out_ready downstream handshake
//   imm_ext, out_tag    extended immediate and its sideband
//   fmt_err             result came from the reserved format code
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr,
  input  logic [FMT_W-1:0]      imm_fmt,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] imm_ext,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  fmt_err
);

  // Decoded input entry
  logic [DATA_WIDTH-1:0] w_new_imm;
  logic                  w_new_err;

  imm_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_imm_decode (
    .instr  (instr),
    .imm_fmt(imm_fmt),
    .imm_ext(w_new_imm),
    .fmt_err(w_new_err)
  );

  // Main (output) register and skid register
  logic                  r_main_valid;
  logic [DATA_WIDTH-1:0] r_main_imm;
  logic [TAG_WIDTH-1:0]  r_main_tag;
  logic                  r_main_err;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_imm;
  logic [TAG_WIDTH-1:0]  r_skid_tag;
  logic                  r_skid_err;
  logic                  r_in_ready;

  // Next-state values
  logic                  w_main_valid_nxt;
  logic [DATA_WIDTH-1:0] w_main_imm_nxt;
  logic [TAG_WIDTH-1:0]  w_main_tag_nxt;
  logic                  w_main_err_nxt;
  logic                  w_skid_valid_nxt;
  logic [DATA_WIDTH-1:0] w_skid_imm_nxt;
  logic [TAG_WIDTH-1:0]  w_skid_tag_nxt;
  logic                  w_skid_err_nxt;
  logic                  w_in_ready_nxt;

  logic w_accept;
  logic w_xfer;
  logic w_main_free;

  assign w_accept    = in_valid && r_in_ready;
  assign w_xfer      = r_main_valid && out_ready;
  assign w_main_free = !r_main_valid || w_xfer;

  // Skid-buffer steering. r_in_ready mirrors !r_skid_valid, so an accept can
  // never coincide with a full skid; the skid always drains into main first.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_imm_nxt   = r_main_imm;
    w_main_tag_nxt   = r_main_tag;
    w_main_err_nxt   = r_main_err;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_imm_nxt   = r_skid_imm;
    w_skid_tag_nxt   = r_skid_tag;
    w_skid_err_nxt   = r_skid_err;

    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        w_main_valid_nxt = 1'b1;
        w_main_imm_nxt   = r_skid_imm;
        w_main_tag_nxt   = r_skid_tag;
        w_main_err_nxt   = r_skid_err;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_main_valid_nxt = 1'b1;
        w_main_imm_nxt   = w_new_imm;
        w_main_tag_nxt   = in_tag;
        w_main_err_nxt   = w_new_err;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_valid_nxt = 1'b1;
      w_skid_imm_nxt   = w_new_imm;
      w_skid_tag_nxt   = in_tag;
      w_skid_err_nxt   = w_new_err;
    end

    w_in_ready_nxt = !w_skid_valid_nxt;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_tag   <= '0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_tag   <= '0;
      r_skid_err   <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_imm   <= w_main_imm_nxt;
      r_main_tag   <= w_main_tag_nxt;
      r_main_err   <= w_main_err_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_imm   <= w_skid_imm_nxt;
      r_skid_tag   <= w_skid_tag_nxt;
      r_skid_err   <= w_skid_err_nxt;
      r_in_ready   <= w_in_ready_nxt;
    end
  end

  assign out_valid = r_main_valid;
  assign imm_ext   = r_main_imm;
  assign out_tag   = r_main_tag;
  assign fmt_err   = r_main_err;
  assign in_ready  = r_in_ready;

endmodule : imm_gen_stage

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined immediate-generation stage for the RV32 decode path. Takes an instruction word plus format select, produces the sign/zero-extended immediate for all RV32I/Zicsr formats, and carries a sideband tag. Registered output behind a valid/ready handshake with a 2-entry skid buffer, so decode can be stalled or flushed without losing or duplicating instructions. Sits between fetch/decode and the execute-stage operand mux; supersedes the 3-format combinational extender.

## Interface
Parameters:
- DATA_WIDTH, 32, immediate/output width; must be ≥ 32.
- TAG_WIDTH, 8, sideband tag width (e.g. rd/PC index), passed through unmodified.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- instr  in  32  instruction word; bits [6:0] ignored.
- imm_fmt  in  3  format select (imm_fmt_t).
- in_tag  in  TAG_WIDTH  sideband.
- flush  in  1  discard all held entries.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- imm_ext  out  DATA_WIDTH  extended immediate.
- out_tag  out  TAG_WIDTH  sideband of that result.
- fmt_err  out  1  result came from an unsupported imm_fmt code.

## Operation
- Formats (i = instr, sign bit i[31] replicated to DATA_WIDTH):
  - I=0: sext(i[31:20]).
  - S=1: sext({i[31:25], i[11:7]}).
  - B=2: sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - U=3: sext({i[31:12], 12'b0}).
  - J=4: sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - SHAMT=5: zext(i[24:20]).
  - CSR_UIMM=6: zext(i[19:15]).
  - 7: imm_ext = 0, fmt_err = 1. fmt_err = 0 for all other codes.
- Accept when in_valid && in_ready; result computed combinationally and registered.
- Storage: main register (drives outputs) plus skid register. Transfer when out_valid && out_ready.
  - Main empty or transferring: accepted entry goes to main (skid, if full, moves to main first; FIFO order always).
  - Main full, no transfer: accepted entry goes to skid.
- in_ready = !skid_valid, driven from a register (no combinational path from out_ready).
- flush: next edge clears main_valid and skid_valid; an input accepted in the flush cycle is discarded; flush overrides transfer and accept.
- Reset: out_valid=0, in_ready=1 (after deassert), imm_ext=0, out_tag=0, fmt_err=0, skid empty.

## Timing
- Latency: accept at edge N → out_valid with result after edge N (visible cycle N+1).
- Throughput: 1 per cycle with out_ready high.
- out_valid, imm_ext, out_tag, fmt_err stable while out_valid && !out_ready.
- Simultaneous accept + transfer with skid empty: main reloads, no bubble.
- Skid full: in_ready low the following cycle; rises one cycle after the skid drains.
- Async reset mid-stream: all entries lost, outputs to reset values immediately.

## Structure
- imm_pkg: imm_fmt_t enum (IMM_I..IMM_CSR, IMM_RSVD=7), opcode-free field position constants.
- Sub-module imm_decode: combinational instr+fmt → imm_ext, fmt_err; instantiated once at the input, parametrised by DATA_WIDTH.
- Top: skid-buffer control + registers.

## Test plan
- I: instr 0xFFF00093, fmt 0 → imm_ext 0xFFFFFFFF one cycle later; S: 0xFE20AE23, fmt 1 → 0xFFFFFFFC.
- B: 0xFE000CE3, fmt 2 → 0xFFFFFFF8; U: 0x123450B7, fmt 3 → 0x12345000; J: 0x0010006F, fmt 4 → 0x00000800; SHAMT: 0x41F0D093, fmt 5 → 0x0000001F.
- fmt 7 with any instr → imm_ext 0, fmt_err 1; following fmt 0 entry → fmt_err 0.
- out_ready low, back-to-back tags 1,2,3 offered → tags 1,2 accepted, in_ready low from cycle after 2nd accept; out_ready high → outputs 1,2,3 in order, no duplicate/drop.
- flush with both entries full and in_valid high → next cycle out_valid 0, in_ready 1, flushed-cycle input never appears.
- rst_n low while out_valid=1 → out_valid/imm_ext/out_tag 0 without a clock edge; normal streaming resumes after release.
